// File: rtl/frv_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents:
//   arb_port_e            : requester port IDs, also stored in the route FIFO
//   ARB_MAX_OUT_DEF       : default limit on granted, unanswered transactions
//   ARB_STARVE_LIMIT_DEF  : default number of cycles port 1 waits before it
//                           takes priority over port 0
package frv_dmem_arbiter_pkg;

    typedef enum logic {
        ARB_P0 = 1'b0,
        ARB_P1 = 1'b1
    } arb_port_e;

    localparam int unsigned ARB_MAX_OUT_DEF      = 2;
    localparam int unsigned ARB_STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/frv_dmem_route_fifo.sv
// In-order FIFO of port IDs, one entry per granted bus transaction.
// Ports:
//   g_clk, g_reset : clock, synchronous active-high reset (empties the FIFO)
//   i_push         : write i_push_id at the tail (ignored when full)
//   i_push_id      : port ID of the transaction just granted
//   i_pop          : drop the head entry (ignored when empty)
//   o_head_id      : port ID that owns the next response
//   o_empty/o_full : occupancy flags
//   o_count        : current occupancy (0..DEPTH)
module frv_dmem_route_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       g_clk,
    input  logic       g_reset,
    input  logic       i_push,
    input  logic       i_push_id,
    input  logic       i_pop,
    output logic       o_head_id,
    output logic       o_empty,
    output logic       o_full,
    output logic [2:0] o_count
);

    localparam int unsigned     PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

    logic          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [2:0]    r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == 3'(DEPTH));
    assign o_count   = r_count;
    assign o_head_id = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frv_dmem_arbiter.sv
// Two-port arbiter onto a single data-memory bus.
// Port 0 (pipeline LSU) has priority; port 1 (secondary requester) is
// promoted after waiting STARVE_LIMIT cycles. Up to MAX_OUT transactions
// may be outstanding; responses are routed back in grant order.
// Ports:
//   g_clk, g_reset          : clock, synchronous active-high reset
//   pX_req/wen/strb/addr/wdata : port X request
//   pX_gnt                  : port X request accepted this cycle
//   pX_recv/error/rdata     : port X response, pX_ack accepts it
//   dmem_*                  : shared bus request/response handshakes
//   outstanding             : granted, unanswered transaction count
module frv_dmem_arbiter
    import frv_dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT      = ARB_MAX_OUT_DEF,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        p0_req,
    input  logic        p0_wen,
    input  logic [3:0]  p0_strb,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_recv,
    output logic        p0_error,
    output logic [31:0] p0_rdata,
    input  logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_wen,
    input  logic [3:0]  p1_strb,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_recv,
    output logic        p1_error,
    output logic [31:0] p1_rdata,
    input  logic        p1_ack,
    output logic        dmem_req,
    output logic        dmem_wen,
    output logic [3:0]  dmem_strb,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_recv,
    input  logic        dmem_error,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_ack,
    output logic [2:0]  outstanding
);

    arb_port_e   w_sel;
    arb_port_e   r_lock_sel;
    logic        r_lock;
    logic [3:0]  r_starve;
    logic        w_sel_req;
    logic        w_head_id;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_sel = ARB_P1;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if ((r_starve == 4'(STARVE_LIMIT)) && p1_req) begin
            w_sel = ARB_P1;
        end else if (p0_req) begin
            w_sel = ARB_P0;
        end
    end

    assign w_sel_req  = (w_sel == ARB_P1) ? p1_req : p0_req;
    // Full blocks the request even if a response pops this cycle.
    assign dmem_req   = !g_reset && w_sel_req && !w_full;
    assign dmem_wen   = (w_sel == ARB_P1) ? p1_wen   : p0_wen;
    assign dmem_strb  = (w_sel == ARB_P1) ? p1_strb  : p0_strb;
    assign dmem_addr  = (w_sel == ARB_P1) ? p1_addr  : p0_addr;
    assign dmem_wdata = (w_sel == ARB_P1) ? p1_wdata : p0_wdata;

    assign p0_gnt = dmem_gnt && dmem_req && (w_sel == ARB_P0);
    assign p1_gnt = dmem_gnt && dmem_req && (w_sel == ARB_P1);

    // Responses arriving with nothing outstanding are acked and dropped.
    assign p0_recv  = !g_reset && dmem_recv && !w_empty && !w_head_id;
    assign p1_recv  = !g_reset && dmem_recv && !w_empty &&  w_head_id;
    assign p0_rdata = p0_recv ? dmem_rdata : '0;
    assign p1_rdata = p1_recv ? dmem_rdata : '0;
    assign p0_error = p0_recv && dmem_error;
    assign p1_error = p1_recv && dmem_error;
    assign dmem_ack = !g_reset && (w_empty || (w_head_id ? p1_ack : p0_ack));

    assign w_push = dmem_req && dmem_gnt;
    assign w_pop  = dmem_recv && dmem_ack && !w_empty;

    frv_dmem_route_fifo #(
        .DEPTH (MAX_OUT)
    ) u_route_fifo (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .i_push    (w_push),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_head_id (w_head_id),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (outstanding)
    );

    // A stalled bus request stays latched on its port until granted; the
    // lock is also released if that port withdraws, so it cannot wedge.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_lock     <= 1'b0;
            r_lock_sel <= ARB_P0;
            r_starve   <= '0;
        end else begin
            r_lock     <= w_sel_req && !(dmem_req && dmem_gnt) && (r_lock || dmem_req);
            r_lock_sel <= w_sel;
            if (!p1_req || p1_gnt) begin
                r_starve <= '0;
            end else if (r_starve != 4'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
module tb_frv_dmem_arbiter;

    localparam int MAXO  = 2;
    localparam int LIMIT = 8;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        p0_req = 0, p0_wen = 0, p0_ack = 0;
    logic [3:0]  p0_strb = '0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_gnt, p0_recv, p0_error;
    logic [31:0] p0_rdata;
    logic        p1_req = 0, p1_wen = 0, p1_ack = 0;
    logic [3:0]  p1_strb = '0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_gnt, p1_recv, p1_error;
    logic [31:0] p1_rdata;
    logic        dmem_req, dmem_wen, dmem_ack;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt = 0, dmem_recv = 0, dmem_error = 0;
    logic [31:0] dmem_rdata = '0;
    logic [2:0]  outstanding;

    always #5 g_clk = ~g_clk;

    frv_dmem_arbiter #(.MAX_OUT(MAXO), .STARVE_LIMIT(LIMIT)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_strb(p0_strb), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_recv(p0_recv), .p0_error(p0_error),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_strb(p1_strb), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_recv(p1_recv), .p1_error(p1_error),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .outstanding(outstanding)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queue of owners of outstanding transactions, how long
    // port 1 has been waiting, and which port (if any) holds a stalled request.
    int q[$];
    int wait_c = 0;
    bit m_lock = 0;
    int m_lp = 0;
    bit m_g0, m_g1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs for the inputs currently driven, advance the model
    // across the next rising edge, and return at the following falling edge.
    task automatic tick();
        int sel, sreq, dreq, hv, head, r0, r1, ack;
        #1;
        chk("outstanding", 32'(outstanding), 32'(q.size()));
        m_g0 = 0;
        m_g1 = 0;
        if (g_reset) begin
            chk("rst_dmem_req", dmem_req, 0);
            chk("rst_p0_gnt", p0_gnt, 0);
            chk("rst_p1_gnt", p1_gnt, 0);
            chk("rst_p0_recv", p0_recv, 0);
            chk("rst_p1_recv", p1_recv, 0);
            chk("rst_dmem_ack", dmem_ack, 0);
            q.delete();
            wait_c = 0;
            m_lock = 0;
        end else begin
            if (m_lock) sel = m_lp;
            else if (wait_c == LIMIT && p1_req) sel = 1;
            else if (p0_req) sel = 0;
            else sel = 1;
            sreq = sel ? int'(p1_req) : int'(p0_req);
            dreq = (sreq != 0 && q.size() < MAXO) ? 1 : 0;
            m_g0 = (dmem_gnt && dreq != 0 && sel == 0);
            m_g1 = (dmem_gnt && dreq != 0 && sel == 1);
            hv   = (q.size() > 0) ? 1 : 0;
            head = hv ? q[0] : 0;
            r0   = (dmem_recv && hv != 0 && head == 0) ? 1 : 0;
            r1   = (dmem_recv && hv != 0 && head == 1) ? 1 : 0;
            ack  = hv ? (head ? int'(p1_ack) : int'(p0_ack)) : 1;
            chk("dmem_req", dmem_req, 32'(dreq));
            chk("dmem_addr", dmem_addr, sel ? p1_addr : p0_addr);
            chk("dmem_wdata", dmem_wdata, sel ? p1_wdata : p0_wdata);
            chk("dmem_wen", dmem_wen, sel ? p1_wen : p0_wen);
            chk("dmem_strb", 32'(dmem_strb), 32'(sel ? p1_strb : p0_strb));
            chk("p0_gnt", p0_gnt, 32'(m_g0));
            chk("p1_gnt", p1_gnt, 32'(m_g1));
            chk("p0_recv", p0_recv, 32'(r0));
            chk("p1_recv", p1_recv, 32'(r1));
            chk("p0_rdata", p0_rdata, r0 ? dmem_rdata : 32'h0);
            chk("p1_rdata", p1_rdata, r1 ? dmem_rdata : 32'h0);
            chk("p0_error", p0_error, 32'(r0 != 0 && dmem_error));
            chk("p1_error", p1_error, 32'(r1 != 0 && dmem_error));
            chk("dmem_ack", dmem_ack, 32'(ack));
            if (dmem_recv && ack != 0 && hv != 0) void'(q.pop_front());
            if (dreq != 0 && dmem_gnt) q.push_back(sel);
            if (!p1_req || m_g1) wait_c = 0;
            else if (wait_c < LIMIT) wait_c++;
            m_lock = (sreq != 0) && !(dreq != 0 && dmem_gnt) && (m_lock || dreq != 0);
            m_lp = sel;
        end
        @(negedge g_clk);
    endtask

    initial begin
        @(negedge g_clk);
        // Reset with every input active.
        p0_req = 1; p1_req = 1; dmem_gnt = 1; dmem_recv = 1; p0_ack = 1; p1_ack = 1;
        tick();
        g_reset = 0;
        p0_req = 0; p1_req = 0; dmem_gnt = 0; dmem_recv = 0;
        chk("rst_outstanding_zero", 32'(outstanding), 0);

        // Both request, bus grants: port 0 wins.
        p0_req = 1; p1_req = 1; dmem_gnt = 1;
        p0_addr = 32'h1000_0000; p1_addr = 32'h2000_0000;
        p0_wdata = 32'hAAAA_0000; p1_wdata = 32'h5555_0000;
        #1;
        chk("both_p0_gnt", p0_gnt, 1);
        chk("both_p1_gnt", p1_gnt, 0);
        tick();
        p0_req = 0; p1_req = 0; dmem_gnt = 0;
        chk("both_outstanding_one", 32'(outstanding), 1);
        dmem_recv = 1; dmem_rdata = 32'hCAFE_0001;
        tick();
        dmem_recv = 0;

        // Stalled p0 request stays on the bus while p1 arrives.
        p0_req = 1; p0_addr = 32'h0000_0100;
        tick();
        p1_req = 1; p1_addr = 32'h0000_0200;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_addr_p0", dmem_addr, 32'h0000_0100);
            tick();
        end
        dmem_gnt = 1;
        #1;
        chk("lock_release_p0_gnt", p0_gnt, 1);
        tick();
        p0_req = 0;
        #1;
        chk("after_lock_p1_gnt", p1_gnt, 1);
        tick();
        p1_req = 0;

        // Full: no new request even when a response pops the same cycle.
        chk("full_outstanding_two", 32'(outstanding), 2);
        p0_req = 1; p0_addr = 32'h0000_0300;
        #1;
        chk("full_no_req", dmem_req, 0);
        tick();
        dmem_recv = 1; dmem_rdata = 32'h1111_2222;
        #1;
        chk("full_pop_no_req", dmem_req, 0);
        chk("order_first_p0", p0_recv, 1);
        tick();
        // Outstanding 1: grant to p0 and response to p1 in the same cycle.
        #1;
        chk("order_second_p1", p1_recv, 1);
        tick();
        p0_req = 0; dmem_gnt = 0;
        chk("pushpop_outstanding", 32'(outstanding), 1);
        #1;
        chk("pushpop_route_p0", p0_recv, 1);
        tick();
        dmem_recv = 0;

        // Port 1 starvation with port 0 always requesting.
        p0_req = 1; p1_req = 1; dmem_gnt = 1; dmem_recv = 1;
        for (int i = 1; i <= 9; i++) begin
            #1;
            chk("starve_p1_gnt", p1_gnt, (i == 9) ? 1 : 0);
            tick();
        end
        p0_req = 0; p1_req = 0; dmem_gnt = 0;
        tick();
        tick();
        dmem_recv = 0;

        // Reset with two transactions outstanding drops routing state.
        p0_req = 1; dmem_gnt = 1;
        tick();
        tick();
        p0_req = 0; dmem_gnt = 0;
        chk("prerst_outstanding", 32'(outstanding), 2);
        g_reset = 1;
        tick();
        g_reset = 0; dmem_recv = 1;
        #1;
        chk("postrst_p0_recv", p0_recv, 0);
        chk("postrst_p1_recv", p1_recv, 0);
        chk("postrst_dmem_ack", dmem_ack, 1);
        chk("postrst_outstanding", 32'(outstanding), 0);
        tick();
        dmem_recv = 0;

        // Randomized traffic; requesters hold a request until granted.
        for (int n = 0; n < 800; n++) begin
            if (!p0_req && ($urandom % 3 == 0)) begin
                p0_req = 1; p0_addr = $urandom; p0_wdata = $urandom;
                p0_wen = 1'($urandom); p0_strb = 4'($urandom);
            end
            if (!p1_req && ($urandom % 3 == 0)) begin
                p1_req = 1; p1_addr = $urandom; p1_wdata = $urandom;
                p1_wen = 1'($urandom); p1_strb = 4'($urandom);
            end
            dmem_gnt   = ($urandom % 5) < 3;
            dmem_recv  = ($urandom % 5) < 2;
            dmem_error = 1'($urandom);
            dmem_rdata = $urandom;
            p0_ack     = ($urandom % 4) != 0;
            p1_ack     = ($urandom % 4) != 0;
            g_reset    = ($urandom % 150) == 0;
            tick();
            if (m_g0) p0_req = 0;
            if (m_g1) p1_req = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
